// File: rtl/sp_sram1024x8_arb_if.sv
// rtl/sp_sram1024x8_arb_if.sv - requester, clear-control and SRAM-side signals of the arbiter
interface sp_sram1024x8_arb_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          clr_start_i;
  logic [DW-1:0] clr_val_i;
  logic          clr_busy_o;
  logic          clr_done_o;

  logic          req0_i;
  logic          we0_i;
  logic [AW-1:0] addr0_i;
  logic [DW-1:0] wdata0_i;
  logic          gnt0_o;
  logic          rvalid0_o;
  logic [DW-1:0] rdata0_o;

  logic          req1_i;
  logic          we1_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata1_i;
  logic          gnt1_o;
  logic          rvalid1_o;
  logic [DW-1:0] rdata1_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_be_o;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  clr_start_i, clr_val_i,
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    input  mem_rdata_i,
    output clr_busy_o, clr_done_o,
    output gnt0_o, rvalid0_o, rdata0_o,
    output gnt1_o, rvalid1_o, rdata1_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output clr_start_i, clr_val_i,
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    output mem_rdata_i,
    input  clr_busy_o, clr_done_o,
    input  gnt0_o, rvalid0_o, rdata0_o,
    input  gnt1_o, rvalid1_o, rdata1_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/sp_sram1024x8_arb.sv
// rtl/sp_sram1024x8_arb.sv - two-port arbiter plus fill engine in front of one single-port SRAM
module sp_sram1024x8_arb #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int FIX_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  sp_sram1024x8_arb_if.slave bus
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic [DW-1:0] r_clr_val;
  logic          r_last_gnt;
  logic [1:0]    r_rd_pend;
  logic          r_clr_done;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_clr_val  <= '0;
      r_last_gnt <= 1'b1;
      r_rd_pend  <= 2'b00;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= (r_state == S_CLEAR) && (&r_clr_cnt);
      if (w_start) r_clr_val <= bus.clr_val_i;
      // Counter wraps to zero on the last word, so the next fill starts at word 0.
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_gnt0 || w_gnt1) r_last_gnt <= w_gnt1;
      r_rd_pend <= {w_gnt1 & ~bus.we1_i, w_gnt0 & ~bus.we0_i};
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt0          = 1'b0;
    w_gnt1          = 1'b0;
    w_start         = 1'b0;
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (bus.clr_start_i) begin
            w_start     = 1'b1;
            w_state_nxt = S_CLEAR;
          end else begin
            w_gnt0 = bus.req0_i & (~bus.req1_i | (FIX_PRIO != 0) | r_last_gnt);
            w_gnt1 = bus.req1_i & ~w_gnt0;
            if (w_gnt0) begin
              bus.mem_en_o    = 1'b1;
              bus.mem_we_o    = bus.we0_i;
              bus.mem_addr_o  = bus.addr0_i;
              bus.mem_wdata_o = bus.wdata0_i;
            end else if (w_gnt1) begin
              bus.mem_en_o    = 1'b1;
              bus.mem_we_o    = bus.we1_i;
              bus.mem_addr_o  = bus.addr1_i;
              bus.mem_wdata_o = bus.wdata1_i;
            end
          end
        end
        S_CLEAR: begin
          bus.mem_en_o    = 1'b1;
          bus.mem_we_o    = 1'b1;
          bus.mem_addr_o  = r_clr_cnt;
          bus.mem_wdata_o = r_clr_val;
          if (&r_clr_cnt) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.mem_be_o   = bus.mem_we_o;
  assign bus.gnt0_o     = w_gnt0;
  assign bus.gnt1_o     = w_gnt1;
  assign bus.clr_busy_o = ~rst & (r_state == S_CLEAR);
  assign bus.clr_done_o = ~rst & r_clr_done;
  assign bus.rvalid0_o  = ~rst & r_rd_pend[0];
  assign bus.rvalid1_o  = ~rst & r_rd_pend[1];
  assign bus.rdata0_o   = bus.rvalid0_o ? bus.mem_rdata_i : '0;
  assign bus.rdata1_o   = bus.rvalid1_o ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_sp_sram1024x8_arb.sv
// tb/tb_sp_sram1024x8_arb.sv - vector table, read-return scoreboard and clear/reset sequences
module tb_sp_sram1024x8_arb;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_sram1024x8_arb_if #(.AW(AW), .DW(DW)) bus ();
  sp_sram1024x8_arb_if #(.AW(AW), .DW(DW)) fbus ();

  sp_sram1024x8_arb #(.AW(AW), .DW(DW), .FIX_PRIO(0)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  sp_sram1024x8_arb #(.AW(AW), .DW(DW), .FIX_PRIO(1)) u_fix (.clk(clk), .rst(rst), .bus(fbus.slave));

  assign fbus.clr_start_i = bus.clr_start_i;
  assign fbus.clr_val_i   = bus.clr_val_i;
  assign fbus.req0_i      = bus.req0_i;
  assign fbus.we0_i       = bus.we0_i;
  assign fbus.addr0_i     = bus.addr0_i;
  assign fbus.wdata0_i    = bus.wdata0_i;
  assign fbus.req1_i      = bus.req1_i;
  assign fbus.we1_i       = bus.we1_i;
  assign fbus.addr1_i     = bus.addr1_i;
  assign fbus.wdata1_i    = bus.wdata1_i;
  assign fbus.mem_rdata_i = '0;

  // SRAM macro behaviour: write on enable+we, registered read data otherwise.
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] ref_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    bus.mem_rdata_i = '0;
  end
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) sram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i      <= sram[bus.mem_addr_o];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0_i   = v.r0; bus.we0_i = v.w0; bus.addr0_i = v.a0; bus.wdata0_i = v.d0;
    bus.req1_i   = v.r1; bus.we1_i = v.w1; bus.addr1_i = v.a1; bus.wdata1_i = v.d1;
  endtask

  task automatic idle();
    bus.req0_i = 1'b0; bus.we0_i = 1'b0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.req1_i = 1'b0; bus.we1_i = 1'b0; bus.addr1_i = '0; bus.wdata1_i = '0;
    bus.clr_start_i = 1'b0;
  endtask

  // Read-return checker: each expected entry must show up exactly on its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      logic e0, e1;
      e0 = (q0.size() > 0) && (q0[0].due == cyc);
      e1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("rvalid0", bus.rvalid0_o, e0);
      chk("rvalid1", bus.rvalid1_o, e1);
      if (e0) begin chk("rdata0", bus.rdata0_o, q0[0].data); void'(q0.pop_front()); end
      else         chk("rdata0_idle", bus.rdata0_o, 0);
      if (e1) begin chk("rdata1", bus.rdata1_o, q1[0].data); void'(q1.pop_front()); end
      else         chk("rdata1_idle", bus.rdata1_o, 0);
    end
  end

  initial begin
    int n;
    int ndone;
    logic [DW-1:0] ew;
    logic [AW-1:0] ea;

    vecs[0]  = '{1,1,10'h005,8'hA5, 0,0,10'h000,8'h00, 1,0};
    vecs[1]  = '{1,0,10'h005,8'h11, 0,0,10'h000,8'h00, 1,0};
    vecs[2]  = '{0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 0,0};
    vecs[3]  = '{0,0,10'h000,8'h00, 1,1,10'h1FF,8'h5A, 0,1};
    vecs[4]  = '{1,0,10'h005,8'h00, 1,0,10'h1FF,8'h00, 1,0};
    vecs[5]  = '{1,0,10'h005,8'h00, 1,0,10'h1FF,8'h00, 0,1};
    vecs[6]  = '{1,0,10'h005,8'h00, 1,0,10'h1FF,8'h00, 1,0};
    vecs[7]  = '{1,0,10'h005,8'h00, 1,0,10'h1FF,8'h00, 0,1};
    vecs[8]  = '{1,0,10'h000,8'h00, 1,1,10'h3FF,8'hC3, 1,0};
    vecs[9]  = '{1,1,10'h3FF,8'h99, 1,0,10'h3FF,8'h00, 0,1};
    vecs[10] = '{1,1,10'h3FF,8'h99, 0,0,10'h000,8'h00, 1,0};
    vecs[11] = '{0,0,10'h000,8'h00, 1,0,10'h3FF,8'h00, 0,1};

    idle();
    bus.clr_val_i = 8'h00;
    rst = 1'b1;
    bus.req0_i = 1'b1; bus.req1_i = 1'b1; bus.clr_start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt0", bus.gnt0_o, 0);
    chk("rst_gnt1", bus.gnt1_o, 0);
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_busy", bus.clr_busy_o, 0);
    chk("rst_done", bus.clr_done_o, 0);
    chk("rst_rvalid0", bus.rvalid0_o, 0);
    idle();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      #1;
      ew = vecs[i].g0 ? vecs[i].w0 : (vecs[i].g1 ? vecs[i].w1 : 1'b0);
      ea = vecs[i].g0 ? vecs[i].a0 : (vecs[i].g1 ? vecs[i].a1 : '0);
      chk($sformatf("v%0d_gnt0", i), bus.gnt0_o, vecs[i].g0);
      chk($sformatf("v%0d_gnt1", i), bus.gnt1_o, vecs[i].g1);
      chk($sformatf("v%0d_mem_en", i), bus.mem_en_o, vecs[i].g0 | vecs[i].g1);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we_o, ew);
      chk($sformatf("v%0d_mem_be", i), bus.mem_be_o, ew);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr_o, ea);
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o,
          vecs[i].g0 ? vecs[i].d0 : (vecs[i].g1 ? vecs[i].d1 : 8'h00));
      chk($sformatf("v%0d_fix_gnt0", i), fbus.gnt0_o, vecs[i].r0);
      chk($sformatf("v%0d_fix_gnt1", i), fbus.gnt1_o, vecs[i].r1 & ~vecs[i].r0);
      if (vecs[i].g0) begin
        if (vecs[i].w0) ref_mem[vecs[i].a0] = vecs[i].d0;
        else q0.push_back('{ref_mem[vecs[i].a0], cyc + 1});
      end
      if (vecs[i].g1) begin
        if (vecs[i].w1) ref_mem[vecs[i].a1] = vecs[i].d1;
        else q1.push_back('{ref_mem[vecs[i].a1], cyc + 1});
      end
    end

    // Read granted just before the clear starts; clear then collides with a held req1.
    @(posedge clk); #1;
    idle();
    bus.req0_i = 1'b1; bus.addr0_i = 10'h005;
    #1;
    chk("pre_clr_gnt0", bus.gnt0_o, 1);
    q0.push_back('{ref_mem[10'h005], cyc + 1});
    @(posedge clk); #1;
    idle();
    bus.clr_start_i = 1'b1; bus.clr_val_i = 8'h3C;
    bus.req1_i = 1'b1; bus.addr1_i = 10'h1FF;
    #1;
    chk("start_gnt1", bus.gnt1_o, 0);
    chk("start_gnt0", bus.gnt0_o, 0);
    chk("start_mem_en", bus.mem_en_o, 0);
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk); #1;
      bus.clr_start_i = 1'b0;
      bus.clr_val_i   = 8'hFF;
      #1;
      if (bus.clr_done_o) break;
      chk("clr_busy", bus.clr_busy_o, 1);
      chk("clr_addr", bus.mem_addr_o, n[AW-1:0]);
      chk("clr_wdata", bus.mem_wdata_o, 8'h3C);
      chk("clr_we", bus.mem_we_o & bus.mem_be_o & bus.mem_en_o, 1);
      chk("clr_gnt1", bus.gnt1_o, 0);
      ref_mem[n[AW-1:0]] = 8'h3C;
      n++;
    end
    chk("clr_cycles", n, 1024);
    chk("clr_done", bus.clr_done_o, 1);
    chk("done_busy", bus.clr_busy_o, 0);
    chk("done_gnt1", bus.gnt1_o, 1);
    chk("done_mem_addr", bus.mem_addr_o, 10'h1FF);
    q1.push_back('{ref_mem[10'h1FF], cyc + 1});
    @(posedge clk); #1;
    idle();
    bus.req0_i = 1'b1; bus.addr0_i = 10'h000;
    #1;
    chk("done_once", bus.clr_done_o, 0);
    chk("post_gnt0_a", bus.gnt0_o, 1);
    q0.push_back('{ref_mem[10'h000], cyc + 1});
    @(posedge clk); #1;
    bus.addr0_i = 10'h3FF;
    #1;
    chk("post_gnt0_b", bus.gnt0_o, 1);
    q0.push_back('{ref_mem[10'h3FF], cyc + 1});
    @(posedge clk); #1;
    idle();

    // Reset in the middle of a fill: abort, no done pulse, restart from word 0.
    @(posedge clk); #1;
    bus.clr_start_i = 1'b1; bus.clr_val_i = 8'h77;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      bus.clr_start_i = 1'b0;
      #1;
      if (bus.clr_busy_o && bus.mem_addr_o == 10'd300) break;
      n++;
    end
    chk("t5_reach300", n, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t5_busy_drop", bus.clr_busy_o, 0);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.clr_done_o || bus.clr_busy_o) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    bus.clr_start_i = 1'b1; bus.clr_val_i = 8'h44;
    @(posedge clk); #1;
    bus.clr_start_i = 1'b0;
    #1;
    chk("t5_restart_busy", bus.clr_busy_o, 1);
    chk("t5_restart_addr", bus.mem_addr_o, 0);
    ndone = 0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk); #1;
      if (bus.clr_done_o) begin ndone++; break; end
    end
    chk("t5_refill_done", ndone, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
